// File: rtl/swap_pkg.sv
// Shared width helpers, round-key field layout and FSM states for the swap_rounds block.
package swap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int blk_w(input int num_tags);
    return $clog2(num_tags);
  endfunction

  function automatic int pos_w(input int tag_size);
    return $clog2(tag_size);
  endfunction

  function automatic int s_w(input int tag_size);
    return $clog2(tag_size + 1);
  endfunction

  function automatic int rk_w(input int tag_size, input int num_tags);
    return 2 * blk_w(num_tags) + 2 * pos_w(tag_size) + s_w(tag_size);
  endfunction

  // Counter never collapses to zero width, even for a single round.
  function automatic int cnt_w(input int rounds);
    return (rounds > 1) ? $clog2(rounds) : 1;
  endfunction

  // Round-key field offsets, LSB first: bx, by, px, py, s.
  localparam int BX_OFF = 0;

  function automatic int by_off(input int num_tags);
    return blk_w(num_tags);
  endfunction

  function automatic int px_off(input int num_tags);
    return 2 * blk_w(num_tags);
  endfunction

  function automatic int py_off(input int tag_size, input int num_tags);
    return 2 * blk_w(num_tags) + pos_w(tag_size);
  endfunction

  function automatic int s_off(input int tag_size, input int num_tags);
    return 2 * blk_w(num_tags) + 2 * pos_w(tag_size);
  endfunction

endpackage

// File: rtl/swap_rounds_if.sv
// Record/key handshake bundle for swap_rounds; o_key_err exists only when
// SWAP_ROUNDS_KEYCHK_EN is defined.
interface swap_rounds_if #(
  parameter int TAG_SIZE = 4,
  parameter int NUM_TAGS = 4,
  parameter int ROUNDS   = 4
);
  import swap_pkg::*;

  localparam int RECORD_SIZE = TAG_SIZE * NUM_TAGS;
  localparam int KEY_SIZE    = ROUNDS * rk_w(TAG_SIZE, NUM_TAGS);

  logic                   i_valid;
  logic                   o_ready;
  logic [RECORD_SIZE-1:0] i_record;
  logic [KEY_SIZE-1:0]    i_key;
  logic                   i_decrypt;
  logic                   o_valid;
  logic                   i_ready;
  logic [RECORD_SIZE-1:0] o_record;
`ifdef SWAP_ROUNDS_KEYCHK_EN
  logic                   o_key_err;

  modport slave (
    input  i_valid, i_record, i_key, i_decrypt, i_ready,
    output o_ready, o_valid, o_record, o_key_err
  );
  modport master (
    output i_valid, i_record, i_key, i_decrypt, i_ready,
    input  o_ready, o_valid, o_record, o_key_err
  );
`else
  modport slave (
    input  i_valid, i_record, i_key, i_decrypt, i_ready,
    output o_ready, o_valid, o_record
  );
  modport master (
    output i_valid, i_record, i_key, i_decrypt, i_ready,
    input  o_ready, o_valid, o_record
  );
`endif

endinterface

// File: rtl/swap_round.sv
// One combinational segment-swap round: exchanges s bits (rotating positions) between tags bx and by.
module swap_round
  import swap_pkg::*;
#(
  parameter int TAG_SIZE = 4,
  parameter int NUM_TAGS = 4
) (
  input  logic [TAG_SIZE*NUM_TAGS-1:0]        i_record,
  input  logic [rk_w(TAG_SIZE, NUM_TAGS)-1:0] i_rk,
  output logic [TAG_SIZE*NUM_TAGS-1:0]        o_record
);

  localparam int RECORD_SIZE = TAG_SIZE * NUM_TAGS;
  localparam int BLK_W  = blk_w(NUM_TAGS);
  localparam int POS_W  = pos_w(TAG_SIZE);
  localparam int S_W    = s_w(TAG_SIZE);
  localparam int BY_OFF = by_off(NUM_TAGS);
  localparam int PX_OFF = px_off(NUM_TAGS);
  localparam int PY_OFF = py_off(TAG_SIZE, NUM_TAGS);
  localparam int S_OFF  = s_off(TAG_SIZE, NUM_TAGS);
  localparam logic [RECORD_SIZE-1:0] TAG_MASK = RECORD_SIZE'({TAG_SIZE{1'b1}});

  int                      w_bx, w_by, w_px, w_py, w_s;
  logic                    w_active;
  logic [TAG_SIZE-1:0]     w_a, w_b, w_ar, w_br, w_mask, w_arn, w_brn, w_an, w_bn;
  logic [2*TAG_SIZE-1:0]   w_an2, w_bn2;
  logic [RECORD_SIZE-1:0]  w_clr;

  // Rotate each tag so the swap window starts at bit 0, swap under a mask, rotate back.
  always_comb begin
    w_bx     = int'(i_rk[BX_OFF +: BLK_W]);
    w_by     = int'(i_rk[BY_OFF +: BLK_W]);
    w_px     = int'(i_rk[PX_OFF +: POS_W]) % TAG_SIZE;
    w_py     = int'(i_rk[PY_OFF +: POS_W]) % TAG_SIZE;
    w_s      = (int'(i_rk[S_OFF +: S_W]) > TAG_SIZE) ? TAG_SIZE : int'(i_rk[S_OFF +: S_W]);
    w_active = (w_s != 0) && (w_bx != w_by) && (w_bx < NUM_TAGS) && (w_by < NUM_TAGS);

    w_a    = TAG_SIZE'(i_record >> (w_bx * TAG_SIZE));
    w_b    = TAG_SIZE'(i_record >> (w_by * TAG_SIZE));
    w_ar   = TAG_SIZE'({w_a, w_a} >> w_px);
    w_br   = TAG_SIZE'({w_b, w_b} >> w_py);
    w_mask = ~({TAG_SIZE{1'b1}} << w_s);
    w_arn  = (w_ar & ~w_mask) | (w_br & w_mask);
    w_brn  = (w_br & ~w_mask) | (w_ar & w_mask);
    w_an2  = {w_arn, w_arn} << w_px;
    w_bn2  = {w_brn, w_brn} << w_py;
    w_an   = w_an2[2*TAG_SIZE-1:TAG_SIZE];
    w_bn   = w_bn2[2*TAG_SIZE-1:TAG_SIZE];
    w_clr  = ~((TAG_MASK << (w_bx * TAG_SIZE)) | (TAG_MASK << (w_by * TAG_SIZE)));

    o_record = i_record;
    if (w_active) begin
      o_record = (i_record & w_clr)
               | (RECORD_SIZE'(w_an) << (w_bx * TAG_SIZE))
               | (RECORD_SIZE'(w_bn) << (w_by * TAG_SIZE));
    end
  end

endmodule

// File: rtl/swap_rounds.sv
// Multi-round segment-swap engine, one round per clock, forward or reverse key order.
// Define SWAP_ROUNDS_KEYCHK_EN to add the sticky o_key_err degenerate-key flag.
module swap_rounds
  import swap_pkg::*;
#(
  parameter int TAG_SIZE = 4,
  parameter int NUM_TAGS = 4,
  parameter int ROUNDS   = 4
) (
  input logic         clk,
  input logic         reset_n,
  swap_rounds_if.slave bus
);

  localparam int RECORD_SIZE = TAG_SIZE * NUM_TAGS;
  localparam int RK_W        = rk_w(TAG_SIZE, NUM_TAGS);
  localparam int KEY_SIZE    = ROUNDS * RK_W;
  localparam int CNT_W       = cnt_w(ROUNDS);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [KEY_SIZE-1:0]    r_key;
  logic                   r_dec;
  logic                   r_ready;
  logic                   r_valid;
  logic [RECORD_SIZE-1:0] r_work;
  logic [RECORD_SIZE-1:0] w_next;
  logic [RK_W-1:0]        w_rk;
  logic                   w_last;
  logic                   w_accept;
  int                     w_ridx;

  always_comb begin
    w_ridx   = r_dec ? (ROUNDS - 1 - int'(r_cnt)) : int'(r_cnt);
    w_rk     = RK_W'(r_key >> (w_ridx * RK_W));
    w_last   = (int'(r_cnt) == ROUNDS - 1);
    w_accept = (r_state == IDLE) && r_ready && bus.i_valid;
  end

  swap_round #(
    .TAG_SIZE (TAG_SIZE),
    .NUM_TAGS (NUM_TAGS)
  ) u_round (
    .i_record (r_work),
    .i_rk     (w_rk),
    .o_record (w_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_key   <= '0;
      r_dec   <= 1'b0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_work  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_work  <= bus.i_record;
            r_key   <= bus.i_key;
            r_dec   <= bus.i_decrypt;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_work <= w_next;
          if (w_last) begin
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_ready  = r_ready;
  assign bus.o_valid  = r_valid;
  assign bus.o_record = r_work;

`ifdef SWAP_ROUNDS_KEYCHK_EN
  localparam int BLK_W  = blk_w(NUM_TAGS);
  localparam int S_W    = s_w(TAG_SIZE);
  localparam int BY_OFF = by_off(NUM_TAGS);
  localparam int S_OFF  = s_off(TAG_SIZE, NUM_TAGS);

  logic r_key_err;
  logic w_degen;
  int   w_kbx, w_kby, w_ks;

  always_comb begin
    w_kbx   = int'(w_rk[BX_OFF +: BLK_W]);
    w_kby   = int'(w_rk[BY_OFF +: BLK_W]);
    w_ks    = int'(w_rk[S_OFF +: S_W]);
    w_degen = (w_ks > TAG_SIZE) || ((w_kbx == w_kby) && (w_ks != 0))
           || (w_kbx >= NUM_TAGS) || (w_kby >= NUM_TAGS);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_err <= 1'b0;
    end else if (w_accept) begin
      r_key_err <= 1'b0;
    end else if (r_state == RUN) begin
      r_key_err <= r_key_err | w_degen;
    end
  end

  assign bus.o_key_err = r_key_err;
`endif

endmodule

// File: doc/swap_rounds.md
Name: swap_rounds

Overview:
- Multi-round, parametrised successor of the single-swap stage.
- Applies ROUNDS sequential segment-swap rounds to one record, one round per clock, each round driven by its own round-key field.
- Supports forward and inverse (reverse round order) modes.
- Sits between the record source and the tag store, with valid/ready handshakes on both sides.

Parameters:
- TAG_SIZE, 4: bits per tag block.
- NUM_TAGS, 4: tag blocks per record; RECORD_SIZE = TAG_SIZE*NUM_TAGS (localparam).
- ROUNDS, 4: swap rounds per record, >=1.
- Derived localparams:
  - BLK_W = clog2(NUM_TAGS)
  - POS_W = clog2(TAG_SIZE)
  - S_W = clog2(TAG_SIZE+1)
  - RK_W = 2*BLK_W + 2*POS_W + S_W
  - KEY_SIZE = ROUNDS*RK_W

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- i_valid  in  1  input record/key valid
- o_ready  out  1  block can accept input
- i_record  in  RECORD_SIZE  record to process
- i_key  in  KEY_SIZE  round keys; round r occupies bits [r*RK_W +: RK_W]
- i_decrypt  in  1  1 = apply rounds ROUNDS-1 down to 0
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_record  out  RECORD_SIZE  processed record

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low (reset_n).
- Reset values: state = IDLE, o_ready = 1, o_valid = 0, o_record = 0, round counter = 0.
- Round-key field layout, LSB first: bx[BLK_W], by[BLK_W], px[POS_W], py[POS_W], s[S_W].
- One round, combinational:
  - A = tag bx, B = tag by.
  - For i < s_eff, where s_eff = min(s, TAG_SIZE): bit (px+i) mod TAG_SIZE of A exchanges with bit (py+i) mod TAG_SIZE of B.
  - All other bits and tags pass through unchanged.
  - s = 0, or bx == by: round is a no-op.
  - bx or by >= NUM_TAGS (non-power-of-2 NUM_TAGS): round is a no-op.
- FSM:
  - IDLE: o_ready = 1. On i_valid && o_ready, capture i_record into the working register, and latch i_key and i_decrypt. Go to RUN, counter = 0.
  - RUN: o_ready = 0. Each edge applies one round to the working register. Round index = counter (forward) or ROUNDS-1-counter (decrypt). Counter increments; after the edge applying the last round, go to DONE.
  - DONE: o_valid = 1 and o_record stable. On i_ready, go to IDLE; o_valid drops and o_ready rises on the next cycle.
- Latency: o_valid is high exactly ROUNDS edges after the accept edge. Throughput is one record per ROUNDS+2 cycles.
- i_valid in RUN or DONE is ignored; the upstream source holds it.
- Changes to i_key and i_decrypt after acceptance have no effect.
- o_record equals the working register; it is only defined while o_valid = 1.
- reset_n low in any state: immediate return to reset values; any in-flight record is discarded.
- ROUNDS = 1: RUN lasts one cycle.

Optional Feature:
- Macro SWAP_ROUNDS_KEYCHK_EN.
- When defined, adds output o_key_err (1 bit, reset 0). It is set sticky in the RUN cycle that uses a degenerate round key and is cleared on the next accept. Degenerate means any of:
  - s > TAG_SIZE
  - bx == by with s != 0
  - bx or by >= NUM_TAGS
- When undefined, there is no port and no logic. Datapath behaviour is identical in both cases.

Decomposition:
- Package swap_pkg holds:
  - clog2-based width functions
  - RK field offset/width localparams
  - FSM state enum (IDLE, RUN, DONE)
- Sub-module swap_round is the purely combinational one-round datapath: record + one RK_W key in, record out. It is instantiated once and fed by the round-key mux.
- swap_rounds holds the FSM, counter, key/mode latches and working register.

Test Plan (defaults, RK_W = 11; unused rounds have s = 0):
- Full-tag swap: record 16'hA5C3, round0 bx=0, by=3, px=0, py=0, s=4 -> o_record 16'h35CA; o_valid exactly 4 edges after accept.
- Partial swap with wrap: record 16'h00F0, round0 bx=0, by=1, px=3, py=0, s=2 -> 16'h00C9.
- Inverse: 100 random records and random keys; result fed back with i_decrypt=1 and the same key -> original record each time.
- Backpressure: i_ready=0 for 10 cycles in DONE -> o_valid, o_record stable, o_ready=0, pulsed i_valid ignored. i_ready=1 -> o_ready=1 next cycle.
- Reset mid-RUN: reset_n low during round 2 -> o_valid=0, o_record=0 immediately; o_ready=1 after release; next accept processes correctly.
- Degenerate keys: bx=by=2 with s=3, and separately s=7 -> bx=by round is a no-op, s=7 is clamped to 4. With SWAP_ROUNDS_KEYCHK_EN, o_key_err=1 and it clears on the next accept.
